// File: rtl/alu_issue_pkg.sv
// Purpose: shared opcodes, funct codes, ALU class codes, FSM state and decode record for the ALU issue controller.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional feature macro ALU_ISSUE_IMM_EN is consumed by alu_issue_decode.
package alu_issue_pkg;

  localparam logic [5:0] OPC_RTYPE    = 6'b000000;
  localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OPC_ADDI     = 6'b001000;
  localparam logic [5:0] OPC_ADDIU    = 6'b001001;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;
  localparam logic [5:0] FUNCT_MOVZ = 6'b001010;
  localparam logic [5:0] FUNCT_MOVN = 6'b001011;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;
  localparam logic [5:0] FUNCT_CLZ  = 6'b100000;
  localparam logic [5:0] FUNCT_CLO  = 6'b100001;

  localparam logic [2:0] ALU_CODE_RTYPE    = 3'b000;
  localparam logic [2:0] ALU_CODE_RSVD1    = 3'b001;
  localparam logic [2:0] ALU_CODE_RSVD2    = 3'b010;
  localparam logic [2:0] ALU_CODE_RSVD3    = 3'b011;
  localparam logic [2:0] ALU_CODE_SPECIAL2 = 3'b100;
  localparam logic [2:0] ALU_CODE_IMM      = 3'b101;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_EXEC, ST_WB} state_t;

  typedef enum logic {A_RS, A_RT} a_sel_t;
  typedef enum logic [1:0] {B_RT, B_RS, B_ZERO, B_IMM} b_sel_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] alu_code;
    logic [5:0] alu_operation;
    a_sel_t     a_sel;
    b_sel_t     b_sel;
    logic [4:0] dest;
    logic       is_movz;
    logic       is_movn;
  } dec_t;

endpackage

// File: rtl/alu_issue_if.sv
// Purpose: bundles the fetch, register-file read, ALU and writeback signals of the ALU issue controller.
// Latency: n/a (wiring only).
// Backpressure: instr_valid/instr_ready on the fetch side, wb_valid/wb_ready on the writeback side.
// Modports: ctrl = the controller (alu_issue_ctrl), env = fetch/regfile/ALU/writeback surroundings.
interface alu_issue_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              instr_valid;
  logic [31:0]       instr;
  logic              instr_ready;
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [5:0]        alu_operation;
  logic [2:0]        alu_code;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic              illegal;
  logic [CNT_W-1:0]  retired;

  modport ctrl (
    input  instr_valid, instr, rs_data, rt_data, alu_result, alu_zero, wb_ready,
    output instr_ready, rs_addr, rt_addr, alu_a, alu_b, alu_operation, alu_code,
           wb_valid, wb_addr, wb_data, illegal, retired
  );

  modport env (
    output instr_valid, instr, rs_data, rt_data, alu_result, alu_zero, wb_ready,
    input  instr_ready, rs_addr, rt_addr, alu_a, alu_b, alu_operation, alu_code,
           wb_valid, wb_addr, wb_data, illegal, retired
  );
endinterface

// File: rtl/alu_issue_decode.sv
// Purpose: combinational MIPS decode of one instruction word into ALU class/function, operand selects and destination.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller samples the result on its accept edge.
// Ports: instr (32-bit word) in, dec (dec_t record) out. Macro ALU_ISSUE_IMM_EN adds ADDI/ADDIU.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] opc;
  logic [5:0] funct;

  assign opc   = instr[31:26];
  assign funct = instr[5:0];

  // shamt is never used: shifts are issued with b=0 and the ALU reads shamt itself if it cares
  logic unused_ok;
  assign unused_ok = ^instr[10:6];

  always_comb begin
    dec               = '0;
    dec.a_sel         = A_RS;
    dec.b_sel         = B_RT;
    dec.alu_operation = funct;
    dec.dest          = instr[15:11];
    case (opc)
      OPC_RTYPE: begin
        dec.alu_code = ALU_CODE_RTYPE;
        case (funct)
          FUNCT_SLL, FUNCT_SRL, FUNCT_SRA: begin
            dec.legal = 1'b1;
            dec.a_sel = A_RT;
            dec.b_sel = B_ZERO;
          end
          FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV: begin
            dec.legal = 1'b1;
            dec.a_sel = A_RT;
            dec.b_sel = B_RS;
          end
          FUNCT_MOVZ: begin
            dec.legal   = 1'b1;
            dec.is_movz = 1'b1;
          end
          FUNCT_MOVN: begin
            dec.legal   = 1'b1;
            dec.is_movn = 1'b1;
          end
          FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU,
          FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR,
          FUNCT_SLT, FUNCT_SLTU: begin
            dec.legal = 1'b1;
          end
          default: dec.legal = 1'b0;
        endcase
      end
      OPC_SPECIAL2: begin
        if (funct == FUNCT_CLZ || funct == FUNCT_CLO) begin
          dec.legal    = 1'b1;
          dec.alu_code = ALU_CODE_SPECIAL2;
          dec.b_sel    = B_ZERO;
        end
      end
`ifdef ALU_ISSUE_IMM_EN
      OPC_ADDI, OPC_ADDIU: begin
        // no funct field here, so the opcode doubles as the function code
        dec.legal         = 1'b1;
        dec.alu_code      = ALU_CODE_IMM;
        dec.alu_operation = opc;
        dec.b_sel         = B_IMM;
        dec.dest          = instr[20:16];
      end
`endif
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Purpose: issues one MIPS ALU instruction at a time: regfile read, ALU drive, result capture, writeback offer.
// Latency: accept to wb_valid 3+ALU_WAIT cycles; one instruction per 4+ALU_WAIT cycles with wb_ready high.
// Backpressure: instr_ready only in IDLE; WB holds wb_valid/wb_addr/wb_data until wb_ready.
// Ports: clk, rst_n (async active-low), bus (alu_issue_if.ctrl). Macro ALU_ISSUE_IMM_EN enables ADDI/ADDIU decode.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALU_WAIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_issue_if.ctrl bus
);

  localparam int WAIT_W = 4;

  dec_t dec;

  alu_issue_decode u_decode (
    .instr (bus.instr),
    .dec   (dec)
  );

  state_t            state_q, state_d;
  logic              instr_ready_q, instr_ready_d;
  logic              illegal_q, illegal_d;
  logic [REG_AW-1:0] rs_addr_q, rs_addr_d;
  logic [REG_AW-1:0] rt_addr_q, rt_addr_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  a_sel_t            a_sel_q, a_sel_d;
  b_sel_t            b_sel_q, b_sel_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              is_movz_q, is_movz_d;
  logic              is_movn_q, is_movn_d;
  logic              rt_zero_q, rt_zero_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [5:0]        alu_operation_q, alu_operation_d;
  logic [2:0]        alu_code_q, alu_code_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              zero_q, zero_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  // the zero flag is captured alongside the result but nothing downstream consumes it
  logic unused_ok;
  assign unused_ok = zero_q;

  always_comb begin
    state_d         = state_q;
    instr_ready_d   = instr_ready_q;
    illegal_d       = 1'b0;
    rs_addr_d       = rs_addr_q;
    rt_addr_d       = rt_addr_q;
    dest_d          = dest_q;
    a_sel_d         = a_sel_q;
    b_sel_d         = b_sel_q;
    imm_d           = imm_q;
    is_movz_d       = is_movz_q;
    is_movn_d       = is_movn_q;
    rt_zero_d       = rt_zero_q;
    alu_a_d         = alu_a_q;
    alu_b_d         = alu_b_q;
    alu_operation_d = alu_operation_q;
    alu_code_d      = alu_code_q;
    cnt_d           = cnt_q;
    wb_valid_d      = wb_valid_q;
    wb_addr_d       = wb_addr_q;
    wb_data_d       = wb_data_q;
    zero_d          = zero_q;
    retired_d       = retired_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid && instr_ready_q) begin
          if (dec.legal) begin
            state_d         = ST_READ;
            instr_ready_d   = 1'b0;
            rs_addr_d       = REG_AW'(bus.instr[25:21]);
            rt_addr_d       = REG_AW'(bus.instr[20:16]);
            dest_d          = REG_AW'(dec.dest);
            a_sel_d         = dec.a_sel;
            b_sel_d         = dec.b_sel;
            imm_d           = {{(DATA_W-16){bus.instr[15]}}, bus.instr[15:0]};
            is_movz_d       = dec.is_movz;
            is_movn_d       = dec.is_movn;
            alu_operation_d = dec.alu_operation;
            alu_code_d      = dec.alu_code;
          end else begin
            // dropped: stay ready, flag it for one cycle
            illegal_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        alu_a_d = (a_sel_q == A_RT) ? bus.rt_data : bus.rs_data;
        case (b_sel_q)
          B_RS:    alu_b_d = bus.rs_data;
          B_ZERO:  alu_b_d = '0;
          B_IMM:   alu_b_d = imm_q;
          default: alu_b_d = bus.rt_data;
        endcase
        rt_zero_d = (bus.rt_data == '0);
        cnt_d     = WAIT_W'(ALU_WAIT);
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          wb_data_d = bus.alu_result;
          zero_d    = bus.alu_zero;
          if ((is_movz_q && !rt_zero_q) || (is_movn_q && rt_zero_q)) begin
            // conditional move not taken: retire without a writeback
            state_d       = ST_IDLE;
            instr_ready_d = 1'b1;
            retired_d     = retired_q + 1'b1;
          end else begin
            state_d    = ST_WB;
            wb_valid_d = 1'b1;
            wb_addr_d  = dest_q;
          end
        end
      end
      ST_WB: begin
        if (bus.wb_ready) begin
          state_d       = ST_IDLE;
          wb_valid_d    = 1'b0;
          instr_ready_d = 1'b1;
          retired_d     = retired_q + 1'b1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        instr_ready_d = 1'b1;
        wb_valid_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      instr_ready_q   <= 1'b1;
      illegal_q       <= 1'b0;
      rs_addr_q       <= '0;
      rt_addr_q       <= '0;
      dest_q          <= '0;
      a_sel_q         <= A_RS;
      b_sel_q         <= B_RT;
      imm_q           <= '0;
      is_movz_q       <= 1'b0;
      is_movn_q       <= 1'b0;
      rt_zero_q       <= 1'b0;
      alu_a_q         <= '0;
      alu_b_q         <= '0;
      alu_operation_q <= '0;
      alu_code_q      <= '0;
      cnt_q           <= '0;
      wb_valid_q      <= 1'b0;
      wb_addr_q       <= '0;
      wb_data_q       <= '0;
      zero_q          <= 1'b0;
      retired_q       <= '0;
    end else begin
      state_q         <= state_d;
      instr_ready_q   <= instr_ready_d;
      illegal_q       <= illegal_d;
      rs_addr_q       <= rs_addr_d;
      rt_addr_q       <= rt_addr_d;
      dest_q          <= dest_d;
      a_sel_q         <= a_sel_d;
      b_sel_q         <= b_sel_d;
      imm_q           <= imm_d;
      is_movz_q       <= is_movz_d;
      is_movn_q       <= is_movn_d;
      rt_zero_q       <= rt_zero_d;
      alu_a_q         <= alu_a_d;
      alu_b_q         <= alu_b_d;
      alu_operation_q <= alu_operation_d;
      alu_code_q      <= alu_code_d;
      cnt_q           <= cnt_d;
      wb_valid_q      <= wb_valid_d;
      wb_addr_q       <= wb_addr_d;
      wb_data_q       <= wb_data_d;
      zero_q          <= zero_d;
      retired_q       <= retired_d;
    end
  end

  assign bus.instr_ready   = instr_ready_q;
  assign bus.illegal       = illegal_q;
  assign bus.rs_addr       = rs_addr_q;
  assign bus.rt_addr       = rt_addr_q;
  assign bus.alu_a         = alu_a_q;
  assign bus.alu_b         = alu_b_q;
  assign bus.alu_operation = alu_operation_q;
  assign bus.alu_code      = alu_code_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_addr       = wb_addr_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.retired       = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Purpose: directed plus randomized stimulus for alu_issue_ctrl with a stub regfile/ALU and an instruction-level model.
// Latency: expects wb_valid W+2 sample points after the accept edge (3+W cycles counting the accept cycle).
// Backpressure: exercises wb_ready stalls of 0..5 cycles and checks the offer is held.
module tb_alu_issue_ctrl;

  localparam int W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) bus ();

  alu_issue_ctrl #(.DATA_W(32), .REG_AW(5), .ALU_WAIT(W), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] regs [32];
  int          checks = 0;
  int          fails  = 0;
  logic [15:0] exp_ret = '0;

  // stub ALU: real add for ADD/ADDU/immediate, pass-through for moves, a scramble for everything else
  function automatic logic [31:0] alu_model(logic [2:0] code, logic [5:0] op, logic [31:0] a, logic [31:0] b);
    if ((code == 3'd0 && (op == 6'h20 || op == 6'h21)) || code == 3'd5) return a + b;
    if (code == 3'd0 && (op == 6'h0a || op == 6'h0b)) return a;
    return a ^ {b[15:0], b[31:16]} ^ {26'd0, op};
  endfunction

  assign bus.rs_data    = regs[bus.rs_addr];
  assign bus.rt_data    = regs[bus.rt_addr];
  assign bus.alu_result = alu_model(bus.alu_code, bus.alu_operation, bus.alu_a, bus.alu_b);
  assign bus.alu_zero   = (bus.alu_result == 32'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // instruction-level reference: what the controller should present to the ALU and write back
  task automatic model(input logic [31:0] ins, input logic [31:0] rsv, input logic [31:0] rtv,
                       output bit legal, output logic [2:0] code, output logic [5:0] op,
                       output logic [31:0] a, output logic [31:0] b, output logic [4:0] dest,
                       output bit write, output bit chk_op);
    logic [5:0] opc, fn;
    opc = ins[31:26];
    fn  = ins[5:0];
    legal = 0; code = 0; op = 0; a = 0; b = 0; dest = 0; write = 1; chk_op = 1;
    if (opc == 6'h00 && (fn inside {6'h0a, 6'h0b, [6'h20:6'h27], 6'h00, 6'h02, 6'h03,
                                    6'h04, 6'h06, 6'h07, 6'h2a, 6'h2b})) begin
      legal = 1; code = 3'd0; op = fn; dest = ins[15:11];
      if (fn inside {6'h00, 6'h02, 6'h03}) begin a = rtv; b = 0; end
      else if (fn inside {6'h04, 6'h06, 6'h07}) begin a = rtv; b = rsv; end
      else begin a = rsv; b = rtv; end
      if (fn == 6'h0a) write = (rtv == 0);
      if (fn == 6'h0b) write = (rtv != 0);
    end else if (opc == 6'h1c && (fn inside {6'h20, 6'h21})) begin
      legal = 1; code = 3'd4; op = fn; a = rsv; b = 0; dest = ins[15:11];
    end
`ifdef ALU_ISSUE_IMM_EN
    else if (opc inside {6'h08, 6'h09}) begin
      legal = 1; code = 3'd5; chk_op = 0; a = rsv; b = {{16{ins[15]}}, ins[15:0]}; dest = ins[20:16];
    end
`endif
  endtask

  task automatic run(input logic [31:0] ins, input logic [31:0] rsv, input logic [31:0] rtv, input int hold);
    bit legal, write, chk_op;
    logic [2:0] code;
    logic [5:0] op;
    logic [31:0] a, b, rs_e, rt_e;
    logic [4:0] dest;
    int n;
    @(negedge clk);
    regs[ins[25:21]] = rsv;
    regs[ins[20:16]] = rtv;
    rs_e = regs[ins[25:21]];
    rt_e = regs[ins[20:16]];
    model(ins, rs_e, rt_e, legal, code, op, a, b, dest, write, chk_op);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    bus.wb_ready    = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = $urandom;
    if (!legal) begin
      chk("illegal_pulse", bus.illegal, 1);
      chk("illegal_ready", bus.instr_ready, 1);
      @(negedge clk);
      chk("illegal_clear", bus.illegal, 0);
      chk("illegal_no_wb", bus.wb_valid, 0);
      chk("illegal_retired", bus.retired, exp_ret);
      return;
    end
    chk("accept_ready", bus.instr_ready, 0);
    chk("accept_illegal", bus.illegal, 0);
    chk("rs_addr", bus.rs_addr, ins[25:21]);
    chk("rt_addr", bus.rt_addr, ins[20:16]);
    n = 0;
    while (!bus.wb_valid && !bus.instr_ready && n < 40) begin
      if (n == 1 || n == W + 1) begin
        chk("alu_a", bus.alu_a, a);
        chk("alu_b", bus.alu_b, b);
        chk("alu_code", bus.alu_code, code);
        if (chk_op) chk("alu_operation", bus.alu_operation, op);
      end
      @(negedge clk);
      n++;
    end
    chk("latency", n, W + 2);
    if (write) begin
      chk("wb_valid", bus.wb_valid, 1);
      chk("wb_addr", bus.wb_addr, dest);
      chk("wb_data", bus.wb_data, alu_model(code, op, a, b));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("stall_valid", bus.wb_valid, 1);
        chk("stall_addr", bus.wb_addr, dest);
        chk("stall_data", bus.wb_data, alu_model(code, op, a, b));
        chk("stall_ready", bus.instr_ready, 0);
      end
      bus.wb_ready = 1'b1;
      @(negedge clk);
      exp_ret++;
      chk("wb_done_valid", bus.wb_valid, 0);
      chk("wb_done_ready", bus.instr_ready, 1);
      chk("wb_done_retired", bus.retired, exp_ret);
    end else begin
      exp_ret++;
      chk("mov_no_wb", bus.wb_valid, 0);
      chk("mov_ready", bus.instr_ready, 1);
      chk("mov_retired", bus.retired, exp_ret);
    end
    bus.wb_ready = 1'b0;
  endtask

  initial begin
    logic [5:0] rfn [18];
    logic [31:0] ins, rtv;
    int seen;
    rfn = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0a, 6'h0b, 6'h20,
            6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
    bus.wb_ready    = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_instr_ready", bus.instr_ready, 1);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_alu_code", bus.alu_code, 0);
    chk("rst_alu_operation", bus.alu_operation, 0);
    chk("rst_wb_addr", bus.wb_addr, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_retired", bus.retired, 0);
    rst_n = 1'b1;

    // ADD r3 = r1 + r2 -> 12
    run({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd5, 32'd7, 0);
    // MOVZ rd=4: rt!=0 suppressed, rt==0 written
    run({6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h0a}, 32'd11, 32'd9, 0);
    run({6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h0a}, 32'd11, 32'd0, 0);
    // MOVN both ways
    run({6'h00, 5'd5, 5'd6, 5'd7, 5'd0, 6'h0b}, 32'd3, 32'd0, 0);
    run({6'h00, 5'd5, 5'd6, 5'd7, 5'd0, 6'h0b}, 32'd3, 32'd1, 0);
    // SRLV: a=rt, b=rs
    run({6'h00, 5'd6, 5'd7, 5'd8, 5'd0, 6'h06}, 32'd2, 32'h80, 0);
    // SLL: a=rt, b=0
    run({6'h00, 5'd0, 5'd9, 5'd10, 5'd4, 6'h00}, 32'h1234, 32'h55, 0);
    // CLZ
    run({6'h1c, 5'd2, 5'd3, 5'd12, 5'd0, 6'h20}, 32'h00ff, 32'h77, 1);
    // writeback stalled for 5 cycles, rd==0 still offered
    run({6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h22}, 32'd40, 32'd2, 5);
    // undecodable
    run(32'hFC000000, 32'd1, 32'd2, 0);
    // ADDI rt=6, imm=-1: legal only with the immediate feature
    run({6'h08, 5'd1, 5'd6, 16'hFFFF}, 32'd10, 32'd3, 0);

    for (int i = 0; i < 60; i++) begin
      ins = $urandom;
      case ($urandom_range(0, 5))
        0, 1, 2: begin ins[31:26] = 6'h00; ins[5:0] = rfn[$urandom_range(0, 17)]; end
        3:       begin ins[31:26] = 6'h1c; ins[5:0] = 6'h20 | 6'($urandom_range(0, 1)); end
        4:       ins[31:26] = 6'h08 | 6'($urandom_range(0, 1));
        default: ;
      endcase
      rtv = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      run(ins, $urandom, rtv, $urandom_range(0, 3));
    end

    // reset while in EXEC abandons the instruction
    @(negedge clk);
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    bus.instr       = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    bus.instr_valid = 1'b1;
    bus.wb_ready    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_alu_a", bus.alu_a, 0);
    chk("midrst_alu_b", bus.alu_b, 0);
    chk("midrst_alu_code", bus.alu_code, 0);
    chk("midrst_alu_operation", bus.alu_operation, 0);
    chk("midrst_ready", bus.instr_ready, 1);
    chk("midrst_wb_valid", bus.wb_valid, 0);
    chk("midrst_retired", bus.retired, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = '0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.wb_valid) seen++;
    end
    chk("midrst_no_wb", seen, 0);
    chk("midrst_ready_after", bus.instr_ready, 1);
    chk("midrst_retired_after", bus.retired, 0);
    bus.wb_ready = 1'b0;

    run({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd5, 32'd7, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
